controller_reader: RTL and testbench
====================================

CONTROLLER_READER -- requirements
Module: controller_reader

Interface
REQ-001 Parameter: HALF_PERIOD, default mapache64::ControllerHalfPeriod (76), clk_12_5875 cycles per controller-clock half period (~6 us); legal range 4..255.
REQ-002 Port: clk_12_5875  input  1  sole clock, GPU pixel clock domain.
REQ-003 Port: rst_B  input  1  asynchronous, active-low reset.
REQ-004 Port: poll_start  input  1  single-cycle request to begin one poll (driven from vblank).
REQ-005 Port: controller_latch  output  1  latch strobe to both controllers, active-high.
REQ-006 Port: controller_clk  output  1  shift clock to both controllers, idle low; controllers shift on its rising edge.
REQ-007 Port: controller_1_data_in_B  input  1  serial data from controller 1, active-low (0 = pressed).
REQ-008 Port: controller_2_data_in_B  input  1  serial data from controller 2, active-low.
REQ-009 Port: controller_1_buttons  output  mapache64::data_t  last complete poll of controller 1, active-high (1 = pressed).
REQ-010 Port: controller_2_buttons  output  mapache64::data_t  last complete poll of controller 2, active-high.
REQ-011 Port: busy  output  1  high from poll acceptance through the DONE cycle.
REQ-012 Port: buttons_valid  output  1  one-cycle pulse when both button registers update.

Function
REQ-013 Both data inputs SHALL pass through a 2-flop synchronizer before any use.
REQ-014 FSM states SHALL be IDLE, LATCH, CLK_LOW, CLK_HIGH, DONE.
REQ-015 IDLE: latch=0, clk=0, busy=0; poll_start=1 -> LATCH on the next edge; phase counter cleared, bit index cleared.
REQ-016 LATCH: latch=1, clk=0, lasts exactly 2*HALF_PERIOD cycles, then -> CLK_LOW.
REQ-017 CLK_LOW: latch=0, clk=0, lasts HALF_PERIOD cycles; on its last cycle both synchronized inputs are sampled, inverted, and shifted into two 8-bit shift registers (shift left, new bit into bit 0, so the first bit read ends in bit 7).
REQ-018 After sampling bit index 7, CLK_LOW -> DONE; otherwise -> CLK_HIGH and bit index increments.
REQ-019 CLK_HIGH: latch=0, clk=1, lasts HALF_PERIOD cycles, then -> CLK_LOW.
REQ-020 DONE: lasts 1 cycle; shift registers copied to both button outputs simultaneously; buttons_valid=1; -> IDLE.
REQ-021 A poll SHALL take 17*HALF_PERIOD+1 cycles from the first LATCH cycle to the DONE cycle inclusive; exactly 7 controller_clk rising edges per poll.
REQ-022 poll_start while busy=1 (including DONE) SHALL be ignored; no queuing.
REQ-023 Button outputs SHALL hold their previous value for the whole poll and change only in DONE; partial polls SHALL never be visible.
REQ-024 controller_latch and controller_clk SHALL be registered outputs, glitch-free, never both high.
REQ-025 Phase counter width SHALL be $clog2(2*HALF_PERIOD); no wrap beyond terminal count.

Reset
REQ-026 rst_B low SHALL immediately force: state IDLE, latch=0, clk=0, busy=0, buttons_valid=0, both button outputs 8'h00, shift registers, counters and synchronizer flops to 0.
REQ-027 Reset mid-poll SHALL abort without updating the button outputs beyond the reset value; the first poll_start after release starts a full fresh poll.

Structure
REQ-028 ControllerHalfPeriod and the FSM state enum SHALL live in package mapache64; data_t is reused from it.
REQ-029 The 2-flop synchronizer SHALL be a separate sub-module, synchronizer, instantiated once per data input.

Verification
REQ-030 HALF_PERIOD=4, controller models loaded 8'hA5 (ctrl 1) and 8'h3C (ctrl 2), poll_start pulse -> latch high 8 cycles, 7 clk pulses, buttons_valid at cycle 69, outputs 8'hA5 / 8'h3C.
REQ-031 Second poll with models changed to 8'h00 / 8'hFF -> outputs remain 8'hA5 / 8'h3C until DONE, then 8'h00 / 8'hFF in the same cycle.
REQ-032 poll_start re-pulsed at cycles 10 and 68 of a poll -> ignored; exactly one buttons_valid pulse; next poll only on a later poll_start.
REQ-033 rst_B asserted at cycle 40 of a poll -> latch, clk, busy go 0 and outputs 8'h00 without a clock edge; new poll after release returns correct values.
REQ-034 Default HALF_PERIOD=76 -> latch width 152 cycles, clk high width 76 cycles, total poll 1293 cycles; checked by assertions on every edge.

Source files
------------

// File: rtl/controller_reader_pkg.sv
// Shared types and constants for the controller polling path.
package mapache64;

    localparam int unsigned ControllerHalfPeriod = 76;

    typedef logic [7:0] data_t;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LOW,
        CLK_HIGH,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/controller_reader_synchronizer.sv
// Two-flop synchronizer for asynchronous controller serial data.
module synchronizer (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/controller_reader.sv
// Polls two serial game controllers: latch, eight clocked reads, then an
// atomic update of both button registers.
module controller_reader
    import mapache64::*;
#(
    parameter int unsigned HALF_PERIOD = ControllerHalfPeriod
) (
    input  logic  clk_12_5875,
    input  logic  rst_B,
    input  logic  poll_start,
    output logic  controller_latch,
    output logic  controller_clk,
    input  logic  controller_1_data_in_B,
    input  logic  controller_2_data_in_B,
    output data_t controller_1_buttons,
    output data_t controller_2_buttons,
    output logic  busy,
    output logic  buttons_valid
);

    localparam int unsigned CW = $clog2(2 * HALF_PERIOD);
    localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_PERIOD - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD - 1);

    ctrl_state_t   r_state;
    ctrl_state_t   w_state_next;
    logic [CW-1:0] r_phase;
    logic [2:0]    r_bit;
    data_t         r_shift1;
    data_t         r_shift2;
    data_t         r_buttons1;
    data_t         r_buttons2;
    logic          r_latch;
    logic          r_clk;
    logic          r_busy;
    logic          r_valid;
    logic          w_data1;
    logic          w_data2;
    logic          w_sample;
    data_t         w_shift1_next;
    data_t         w_shift2_next;

    synchronizer u_sync1 (
        .i_clk   (clk_12_5875),
        .i_rst_n (rst_B),
        .i_d     (controller_1_data_in_B),
        .o_q     (w_data1)
    );

    synchronizer u_sync2 (
        .i_clk   (clk_12_5875),
        .i_rst_n (rst_B),
        .i_d     (controller_2_data_in_B),
        .o_q     (w_data2)
    );

    always_comb begin
        w_state_next = r_state;
        w_sample     = 1'b0;
        case (r_state)
            IDLE: begin
                if (poll_start) w_state_next = LATCH;
            end
            LATCH: begin
                if (r_phase == LATCH_LAST) w_state_next = CLK_LOW;
            end
            CLK_LOW: begin
                if (r_phase == HALF_LAST) begin
                    w_sample     = 1'b1;
                    w_state_next = (r_bit == 3'd7) ? DONE : CLK_HIGH;
                end
            end
            CLK_HIGH: begin
                if (r_phase == HALF_LAST) w_state_next = CLK_LOW;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Data is active-low on the wire; store it active-high.
    assign w_shift1_next = {r_shift1[6:0], ~w_data1};
    assign w_shift2_next = {r_shift2[6:0], ~w_data2};

    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            r_state <= IDLE;
            r_phase <= '0;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE || w_state_next != r_state) r_phase <= '0;
            else                                           r_phase <= r_phase + CW'(1);
            if (r_state == IDLE)              r_bit <= '0;
            else if (w_sample && r_bit != 3'd7) r_bit <= r_bit + 3'd1;
        end
    end

    // Outputs are registered off the next state so they align with r_state
    // while still coming straight from flops.
    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            r_shift1   <= '0;
            r_shift2   <= '0;
            r_buttons1 <= '0;
            r_buttons2 <= '0;
            r_latch    <= 1'b0;
            r_clk      <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            if (w_sample) begin
                r_shift1 <= w_shift1_next;
                r_shift2 <= w_shift2_next;
            end
            if (w_state_next == DONE) begin
                r_buttons1 <= w_shift1_next;
                r_buttons2 <= w_shift2_next;
            end
            r_latch <= (w_state_next == LATCH);
            r_clk   <= (w_state_next == CLK_HIGH);
            r_busy  <= (w_state_next != IDLE);
            r_valid <= (w_state_next == DONE);
        end
    end

    assign controller_latch     = r_latch;
    assign controller_clk       = r_clk;
    assign busy                 = r_busy;
    assign buttons_valid        = r_valid;
    assign controller_1_buttons = r_buttons1;
    assign controller_2_buttons = r_buttons2;

endmodule

// File: tb/tb_controller_reader.sv
// Self-checking bench: controller models feed the reader; polls are checked
// against loaded values and cycle-level timing derived from the half period.
module tb_controller_reader;

    localparam int unsigned HP       = 4;
    localparam int unsigned POLL_CYC = 17 * HP + 1;
    localparam int unsigned NVEC     = 6;

    typedef struct {
        logic [7:0] c1;
        logic [7:0] c2;
        bit         repulse;
        logic [7:0] e1;
        logic [7:0] e2;
    } vec_t;

    logic clk = 1'b0;
    logic rst_B = 1'b0;
    logic poll_start = 1'b0;
    logic latch, cclk, d1_B, d2_B, busy, valid;
    logic [7:0] b1, b2;

    logic poll76 = 1'b0;
    logic latch76, cclk76, busy76, valid76;
    logic [7:0] b1_76, b2_76;
    logic one = 1'b1;

    logic [7:0] m_val1 = '0, m_val2 = '0, m_sh1 = '0, m_sh2 = '0;
    logic       m_prev = 1'b0;
    logic [7:0] exp1 = '0, exp2 = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    controller_reader #(.HALF_PERIOD(HP)) dut (
        .clk_12_5875            (clk),
        .rst_B                  (rst_B),
        .poll_start             (poll_start),
        .controller_latch       (latch),
        .controller_clk         (cclk),
        .controller_1_data_in_B (d1_B),
        .controller_2_data_in_B (d2_B),
        .controller_1_buttons   (b1),
        .controller_2_buttons   (b2),
        .busy                   (busy),
        .buttons_valid          (valid)
    );

    controller_reader dut76 (
        .clk_12_5875            (clk),
        .rst_B                  (rst_B),
        .poll_start             (poll76),
        .controller_latch       (latch76),
        .controller_clk         (cclk76),
        .controller_1_data_in_B (one),
        .controller_2_data_in_B (one),
        .controller_1_buttons   (b1_76),
        .controller_2_buttons   (b2_76),
        .busy                   (busy76),
        .buttons_valid          (valid76)
    );

    // Parallel-in shift-register controllers: load while latched, shift on
    // each rising controller clock, first bit presented is bit 7.
    always @(posedge clk) begin
        if (latch) begin
            m_sh1 <= m_val1;
            m_sh2 <= m_val2;
        end else if (cclk && !m_prev) begin
            m_sh1 <= {m_sh1[6:0], 1'b0};
            m_sh2 <= {m_sh2[6:0], 1'b0};
        end
        m_prev <= cclk;
    end
    assign d1_B = ~m_sh1[7];
    assign d2_B = ~m_sh2[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_B && (latch || cclk || latch76 || cclk76)) begin
            chk("latch_clk_exclusive", {30'd0, latch & cclk, latch76 & cclk76}, 32'd0);
        end
    end

    task automatic do_poll(input logic [7:0] a, input logic [7:0] b, input bit repulse,
                           input logic [7:0] ea, input logic [7:0] eb);
        int   cyc    = 1;
        int   lat    = 0;
        int   rises  = 0;
        int   extra  = 0;
        logic prevc  = 1'b0;
        m_val1 = a;
        m_val2 = b;
        @(negedge clk);
        poll_start = 1'b1;
        @(negedge clk);
        forever begin
            if (latch) lat++;
            if (cclk && !prevc) rises++;
            prevc = cclk;
            poll_start = repulse && (cyc == 10 || cyc == 68);
            if (valid || cyc >= 200) break;
            chk("held_b1", b1, exp1);
            chk("held_b2", b2, exp2);
            chk("busy_in_poll", busy, 1);
            @(negedge clk);
            cyc++;
        end
        chk("poll_cycles", cyc, POLL_CYC);
        chk("latch_width", lat, 2 * HP);
        chk("clk_rises", rises, 7);
        chk("busy_in_done", busy, 1);
        chk("buttons1", b1, ea);
        chk("buttons2", b2, eb);
        exp1 = ea;
        exp2 = eb;
        for (int i = 0; i < 2 * int'(POLL_CYC) - 60; i++) begin
            @(negedge clk);
            if (valid || busy) extra++;
        end
        chk("no_second_poll", extra, 0);
        chk("hold_after_b1", b1, ea);
        chk("hold_after_b2", b2, eb);
    endtask

    vec_t vec [NVEC];

    initial begin
        int cyc, lat, hi, highs;
        vec[0] = '{8'hA5, 8'h3C, 1'b0, 8'hA5, 8'h3C};
        vec[1] = '{8'h00, 8'hFF, 1'b0, 8'h00, 8'hFF};
        vec[2] = '{8'h81, 8'h7E, 1'b1, 8'h81, 8'h7E};
        for (int i = 3; i < int'(NVEC); i++) begin
            vec[i].c1      = 8'($urandom);
            vec[i].c2      = 8'($urandom);
            vec[i].repulse = bit'($urandom_range(1));
            vec[i].e1      = vec[i].c1;
            vec[i].e2      = vec[i].c2;
        end

        #12;
        chk("rst_latch", latch, 0);
        chk("rst_clk", cclk, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_b1", b1, 8'h00);
        chk("rst_b2", b2, 8'h00);
        @(negedge clk);
        rst_B = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < int'(NVEC); i++) begin
            do_poll(vec[i].c1, vec[i].c2, vec[i].repulse, vec[i].e1, vec[i].e2);
        end

        // Reset in the middle of a poll.
        m_val1 = 8'h5A;
        m_val2 = 8'hC3;
        @(negedge clk);
        poll_start = 1'b1;
        @(negedge clk);
        poll_start = 1'b0;
        repeat (39) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        #1;
        rst_B = 1'b0;
        #1;
        chk("async_rst_latch", latch, 0);
        chk("async_rst_clk", cclk, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_b1", b1, 8'h00);
        chk("async_rst_b2", b2, 8'h00);
        exp1 = '0;
        exp2 = '0;
        @(negedge clk);
        rst_B = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", busy, 0);
        do_poll(8'h5A, 8'hC3, 1'b0, 8'h5A, 8'hC3);

        // Default half period timing.
        @(negedge clk);
        poll76 = 1'b1;
        @(negedge clk);
        poll76 = 1'b0;
        cyc = 1; lat = 0; hi = 0; highs = 0;
        while (!valid76 && cyc < 3000) begin
            if (latch76) lat++;
            if (cclk76) hi++;
            else if (hi != 0) begin
                chk("clk_high_width76", hi, 76);
                highs++;
                hi = 0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("poll_len76", cyc, 1293);
        chk("latch_width76", lat, 152);
        chk("clk_pulses76", highs, 7);
        chk("buttons76", {b1_76, b2_76}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
